// File: rtl/la_spram_seq_pkg.sv
// Shared constants for the sequenced gf180 single-port RAM.
// Lane width, FSM encodings and macro geometry helpers.
package la_spram_seq_pkg;

    localparam int LW = 8;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Macro address width: smallest macro is 64 rows, largest 512.
    function automatic int macro_aw(input int aw);
        if (aw < 6) return 6;
        if (aw > 9) return 9;
        return aw;
    endfunction

    function automatic int lanes(input int dw);
        return (dw + LW - 1) / LW;
    endfunction

endpackage

// File: rtl/la_spram_seq_if.sv
// Request/response bus of la_spram_seq.
// master: requester (core/cache); slave: the RAM.
interface la_spram_seq_if #(
    parameter int DW = 32,
    parameter int AW = 10
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [DW-1:0] req_wmask;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_din;
    logic          rsp_valid;
    logic [DW-1:0] rsp_dout;

    modport master (
        output req_valid, req_we, req_wmask, req_addr, req_din,
        input  req_ready, rsp_valid, rsp_dout
    );

    modport slave (
        input  req_valid, req_we, req_wmask, req_addr, req_din,
        output req_ready, rsp_valid, rsp_dout
    );
endinterface

// File: rtl/la_spram_seq_bank.sv
// One bank of ceil(DW/8) 8-bit macro lanes with active-low pins.
// Ports: clk, cen, gwen, wen (per bit), a, d in; q out (registered).
module la_spram_seq_bank
    import la_spram_seq_pkg::*;
#(
    parameter int DW = 32,
    parameter int MD = 9
) (
    input  logic          clk,
    input  logic          cen,
    input  logic          gwen,
    input  logic [DW-1:0] wen,
    input  logic [MD-1:0] a,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);
    localparam int NL = lanes(DW);
    localparam int PW = NL * LW;

    logic [PW-1:0] wen_p;
    logic [PW-1:0] d_p;
    logic [PW-1:0] q_p;
    logic          unused_q;

    // Padding bits of the last lane are never written.
    always_comb begin
        wen_p          = '1;
        wen_p[DW-1:0]  = wen;
        d_p            = '0;
        d_p[DW-1:0]    = d;
    end

    for (genvar l = 0; l < NL; l++) begin : g_lane
        logic [LW-1:0] mem [2**MD];
        logic [LW-1:0] qr;

        always_ff @(posedge clk) begin
            if (!cen) begin
                if (gwen) begin
                    qr <= mem[a];
                end else begin
                    for (int i = 0; i < LW; i++) begin
                        if (!wen_p[l*LW+i]) begin
                            mem[a][i] <= d_p[l*LW+i];
                        end
                    end
                end
            end
        end

        assign q_p[l*LW +: LW] = qr;
    end

    assign q        = q_p[DW-1:0];
    assign unused_q = ^q_p;

endmodule

// File: rtl/la_spram_seq.sv
// Sequenced single-port RAM: handshake, read pipe, zero-init FSM.
// Ports: clk, nreset, bus (slave), init_req/init_busy, power, ctrl, test.
module la_spram_seq
    import la_spram_seq_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 10,
    parameter int INIT   = 1,
    parameter int OUTREG = 0,
    parameter int CTRLW  = 128,
    parameter int TESTW  = 128
) (
    input  logic             clk,
    input  logic             nreset,
    la_spram_seq_if.slave    bus,
    input  logic             init_req,
    output logic             init_busy,
    input  logic             vss,
    input  logic             vdd,
    input  logic             vddio,
    input  logic [CTRLW-1:0] ctrl,
    input  logic [TESTW-1:0] test
);
    localparam int MD = macro_aw(AW);
    localparam int NB = (AW > MD) ? 2**(AW-MD) : 1;
    localparam int BW = (AW > MD) ? AW - MD : 1;

    logic [1:0]    state;
    logic [MD-1:0] cnt;
    logic          accept;
    logic          in_init;
    logic          rd_v1;
    logic          inflight;
    logic [BW-1:0] bidx;
    logic [BW-1:0] bsel1;
    logic [MD-1:0] a_req;
    logic [MD-1:0] a_mac;
    logic [DW-1:0] q [NB];
    logic [DW-1:0] rd_data;
    logic          unused_pins;

    assign bus.req_ready = (state == ST_IDLE) & ~init_req;
    assign accept        = bus.req_valid & bus.req_ready;
    assign in_init       = (state == ST_INIT);
    assign init_busy     = (state != ST_IDLE);
    assign unused_pins   = ^{vss, vdd, vddio, ctrl, test};

    // Narrow arrays still use a 64-row macro; upper rows unreachable.
    if (AW >= MD) begin : g_a_full
        assign a_req = bus.req_addr[MD-1:0];
    end else begin : g_a_pad
        assign a_req = {{(MD-AW){1'b0}}, bus.req_addr};
    end

    if (NB > 1) begin : g_bidx
        assign bidx = bus.req_addr[AW-1:MD];
    end else begin : g_bidx1
        assign bidx = '0;
    end

    assign a_mac = in_init ? cnt : a_req;

    for (genvar b = 0; b < NB; b++) begin : g_bank
        la_spram_seq_bank #(
            .DW (DW),
            .MD (MD)
        ) u_bank (
            .clk  (clk),
            .cen  (~(in_init | (accept & (bidx == BW'(b))))),
            .gwen (~in_init & ~bus.req_we),
            .wen  (in_init ? '0 : ~bus.req_wmask),
            .a    (a_mac),
            .d    (in_init ? '0 : bus.req_din),
            .q    (q[b])
        );
    end

    // Mux on the bank captured at accept, never the live address.
    if (NB > 1) begin : g_mux
        assign rd_data = q[bsel1];
    end else begin : g_mux1
        assign rd_data = q[0];
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= (INIT != 0) ? ST_INIT : ST_IDLE;
            cnt   <= '0;
            rd_v1 <= 1'b0;
            bsel1 <= '0;
        end else begin
            rd_v1 <= accept & ~bus.req_we;
            if (accept) begin
                bsel1 <= bidx;
            end
            case (state)
                ST_INIT: begin
                    cnt <= cnt + MD'(1);
                    if (&cnt) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (init_req) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!inflight) begin
                        state <= ST_INIT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    if (OUTREG != 0) begin : g_oreg
        logic          rsp_v2;
        logic [DW-1:0] dout_r;

        always_ff @(posedge clk or negedge nreset) begin
            if (!nreset) begin
                rsp_v2 <= 1'b0;
                dout_r <= '0;
            end else begin
                rsp_v2 <= rd_v1;
                if (rd_v1) begin
                    dout_r <= rd_data;
                end
            end
        end

        assign bus.rsp_valid = rsp_v2;
        assign bus.rsp_dout  = dout_r;
        assign inflight      = rd_v1 | rsp_v2;
    end else begin : g_noreg
        assign bus.rsp_valid = rd_v1;
        assign bus.rsp_dout  = rd_data;
        assign inflight      = rd_v1;
    end

endmodule

// File: tb/tb_la_spram_seq.sv
// Bench for la_spram_seq: OUTREG=0/1 pair in lockstep plus DW=12 AW=5.
// Reference memory model and a response scoreboard with due cycles.
module tb_la_spram_seq;

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic nreset;
    logic init_req;
    logic init_req_c;
    logic busy_a, busy_b, busy_c;
    logic vss, vdd;
    logic [127:0] ctrl, test;

    logic        s_valid, s_we;
    logic [9:0]  s_addr;
    logic [31:0] s_din, s_mask;
    logic        c_valid, c_we;
    logic [4:0]  c_addr;
    logic [11:0] c_din, c_mask;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    exp_t qa[$], qb[$], qc[$];
    exp_t ea, eb, ec;
    logic [31:0] ma [1024];
    logic [11:0] mc [32];

    la_spram_seq_if #(.DW(32), .AW(10)) ia ();
    la_spram_seq_if #(.DW(32), .AW(10)) ib ();
    la_spram_seq_if #(.DW(12), .AW(5))  ic ();

    assign ia.req_valid = s_valid;
    assign ia.req_we    = s_we;
    assign ia.req_addr  = s_addr;
    assign ia.req_din   = s_din;
    assign ia.req_wmask = s_mask;
    assign ib.req_valid = s_valid;
    assign ib.req_we    = s_we;
    assign ib.req_addr  = s_addr;
    assign ib.req_din   = s_din;
    assign ib.req_wmask = s_mask;
    assign ic.req_valid = c_valid;
    assign ic.req_we    = c_we;
    assign ic.req_addr  = c_addr;
    assign ic.req_din   = c_din;
    assign ic.req_wmask = c_mask;

    la_spram_seq #(
        .DW(32), .AW(10), .INIT(1), .OUTREG(0), .CTRLW(128), .TESTW(128)
    ) u_a (
        .clk(clk), .nreset(nreset), .bus(ia),
        .init_req(init_req), .init_busy(busy_a),
        .vss(vss), .vdd(vdd), .vddio(vdd), .ctrl(ctrl), .test(test)
    );

    la_spram_seq #(
        .DW(32), .AW(10), .INIT(1), .OUTREG(1), .CTRLW(128), .TESTW(128)
    ) u_b (
        .clk(clk), .nreset(nreset), .bus(ib),
        .init_req(init_req), .init_busy(busy_b),
        .vss(vss), .vdd(vdd), .vddio(vdd), .ctrl(ctrl), .test(test)
    );

    la_spram_seq #(
        .DW(12), .AW(5), .INIT(1), .OUTREG(0), .CTRLW(128), .TESTW(128)
    ) u_c (
        .clk(clk), .nreset(nreset), .bus(ic),
        .init_req(init_req_c), .init_busy(busy_c),
        .vss(vss), .vdd(vdd), .vddio(vdd), .ctrl(ctrl), .test(test)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, cyc=%0d", cyc);
        $fatal(1);
    end

    // Scoreboard: each rsp_valid pops one expectation, due cycle included.
    always @(negedge clk) begin
        if (nreset) begin
            if (ia.rsp_valid) begin
                n_cmp++;
                if (qa.size() == 0) begin
                    n_bad++;
                    $display("FAIL rsp_a spurious: got %h", ia.rsp_dout);
                end else begin
                    ea = qa.pop_front();
                    if (ia.rsp_dout !== ea.d || cyc != ea.due) begin
                        n_bad++;
                        $display("FAIL rsp_a: got %h @%0d, want %h @%0d",
                                 ia.rsp_dout, cyc, ea.d, ea.due);
                    end
                end
            end else if (qa.size() != 0 && qa[0].due <= cyc) begin
                n_cmp++;
                n_bad++;
                ea = qa.pop_front();
                $display("FAIL rsp_a missing: got none, want %h @%0d", ea.d, ea.due);
            end
            if (ib.rsp_valid) begin
                n_cmp++;
                if (qb.size() == 0) begin
                    n_bad++;
                    $display("FAIL rsp_b spurious: got %h", ib.rsp_dout);
                end else begin
                    eb = qb.pop_front();
                    if (ib.rsp_dout !== eb.d || cyc != eb.due) begin
                        n_bad++;
                        $display("FAIL rsp_b: got %h @%0d, want %h @%0d",
                                 ib.rsp_dout, cyc, eb.d, eb.due);
                    end
                end
            end else if (qb.size() != 0 && qb[0].due <= cyc) begin
                n_cmp++;
                n_bad++;
                eb = qb.pop_front();
                $display("FAIL rsp_b missing: got none, want %h @%0d", eb.d, eb.due);
            end
            if (ic.rsp_valid) begin
                n_cmp++;
                if (qc.size() == 0) begin
                    n_bad++;
                    $display("FAIL rsp_c spurious: got %h", ic.rsp_dout);
                end else begin
                    ec = qc.pop_front();
                    if (ic.rsp_dout !== ec.d[11:0] || cyc != ec.due) begin
                        n_bad++;
                        $display("FAIL rsp_c: got %h @%0d, want %h @%0d",
                                 ic.rsp_dout, cyc, ec.d[11:0], ec.due);
                    end
                end
            end else if (qc.size() != 0 && qc[0].due <= cyc) begin
                n_cmp++;
                n_bad++;
                ec = qc.pop_front();
                $display("FAIL rsp_c missing: got none, want %h @%0d", ec.d[11:0], ec.due);
            end
        end
    end

    task automatic zero_models();
        for (int i = 0; i < 1024; i++) ma[i] = '0;
        for (int i = 0; i < 32; i++) mc[i] = '0;
    endtask

    // Drive one request to both 32-bit DUTs; accepted at the next posedge.
    task automatic issue(input logic we, input logic [9:0] addr,
                         input logic [31:0] din, input logic [31:0] mask);
        int k;
        s_valid = 1'b0;
        s_we    = we;
        s_addr  = addr;
        s_din   = din;
        s_mask  = mask;
        #1;
        k = 0;
        while (!(ia.req_ready && ib.req_ready) && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (k >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_ready: ready a=%b b=%b, want 1", ia.req_ready, ib.req_ready);
        end
        s_valid = 1'b1;
        if (we) begin
            ma[addr] = (ma[addr] & ~mask) | (din & mask);
        end else begin
            qa.push_back('{d: ma[addr], due: cyc + 1});
            qb.push_back('{d: ma[addr], due: cyc + 2});
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic issue_c(input logic we, input logic [4:0] addr,
                           input logic [11:0] din, input logic [11:0] mask);
        int k;
        c_valid = 1'b0;
        c_we    = we;
        c_addr  = addr;
        c_din   = din;
        c_mask  = mask;
        #1;
        k = 0;
        while (!ic.req_ready && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (k >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_c_ready: ready=%b, want 1", ic.req_ready);
        end
        c_valid = 1'b1;
        if (we) begin
            mc[addr] = (mc[addr] & ~mask) | (din & mask);
        end else begin
            qc.push_back('{d: {20'h0, mc[addr]}, due: cyc + 1});
        end
        @(negedge clk);
        c_valid = 1'b0;
    endtask

    task automatic drain_rsp(input string name);
        int k;
        k = 0;
        #1;
        while ((qa.size() + qb.size() + qc.size()) != 0 && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        n_cmp++;
        if ((qa.size() + qb.size() + qc.size()) != 0) begin
            n_bad++;
            $display("FAIL %s drain: pending a=%0d b=%0d c=%0d, want 0",
                     name, qa.size(), qb.size(), qc.size());
            qa.delete();
            qb.delete();
            qc.delete();
        end
    endtask

    // Counts sampled cycles with init_busy high; optional init_req poke.
    task automatic count_init(input int poke, output int na, output int nb,
                              output int nc, output int nr);
        na = 0;
        nb = 0;
        nc = 0;
        nr = 0;
        #1;
        for (int k = 0; k < 700; k++) begin
            if (busy_a) na++;
            if (busy_b) nb++;
            if (busy_c) nc++;
            if ((busy_a && ia.req_ready) || (busy_b && ib.req_ready)) nr++;
            init_req = (k == poke);
            @(negedge clk);
            #1;
        end
        init_req = 1'b0;
    endtask

    task automatic test_reset();
        int na, nb, nc, nr;
        nreset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (ia.req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_ready: got %b, want 0", ia.req_ready);
        end
        n_cmp++;
        if (ia.rsp_valid !== 1'b0 || ib.rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_rsp_valid: got a=%b b=%b, want 0", ia.rsp_valid, ib.rsp_valid);
        end
        n_cmp++;
        if (ib.rsp_dout !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_dout_b: got %h, want 0", ib.rsp_dout);
        end
        n_cmp++;
        if (busy_a !== 1'b1 || busy_c !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_busy: got a=%b c=%b, want 1", busy_a, busy_c);
        end
        @(negedge clk);
        nreset = 1'b1;
        count_init(-1, na, nb, nc, nr);
        zero_models();
        n_cmp++;
        if (na != 512 || nb != 512) begin
            n_bad++;
            $display("FAIL init_len: got a=%0d b=%0d, want 512", na, nb);
        end
        n_cmp++;
        if (nc != 64) begin
            n_bad++;
            $display("FAIL init_len_c: got %0d, want 64", nc);
        end
        n_cmp++;
        if (ia.req_ready !== 1'b1 || ic.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL post_init_ready: got a=%b c=%b, want 1", ia.req_ready, ic.req_ready);
        end
        issue(1'b0, 10'h3FF, 32'h0, 32'h0);
        drain_rsp("reset_read");
    endtask

    task automatic test_write_read();
        issue(1'b1, 10'h005, 32'hDEADBEEF, 32'hFFFFFFFF);
        issue(1'b1, 10'h200, 32'hABCD1234, 32'h0000FFFF);
        issue(1'b0, 10'h005, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        issue(1'b0, 10'h200, 32'h0, 32'h0);
        drain_rsp("write_read");
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 10'h205, 32'h55AA55AA, 32'hFFFFFFFF);
        issue(1'b0, 10'h005, 32'h0, 32'h0);
        issue(1'b0, 10'h205, 32'h0, 32'h0);
        issue(1'b0, 10'h005, 32'h0, 32'h0);
        issue(1'b1, 10'h3FE, 32'h0F0F0F0F, 32'hFF00FF00);
        issue(1'b0, 10'h3FE, 32'h0, 32'h0);
        issue(1'b0, 10'h200, 32'h0, 32'h0);
        drain_rsp("back_to_back");
    endtask

    task automatic test_dw12();
        issue_c(1'b1, 5'h1F, 12'hFFF, 12'hFFF);
        issue_c(1'b1, 5'h00, 12'h0A5, 12'h0F0);
        issue_c(1'b0, 5'h1F, 12'h0, 12'h0);
        issue_c(1'b0, 5'h00, 12'h0, 12'h0);
        issue_c(1'b0, 5'h01, 12'h0, 12'h0);
        drain_rsp("dw12");
    endtask

    task automatic test_init_req();
        int na, nb, nc, nr;
        issue(1'b0, 10'h005, 32'h0, 32'h0);
        init_req = 1'b1;
        #1;
        n_cmp++;
        if (ia.req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL init_req_ready: got %b, want 0", ia.req_ready);
        end
        @(negedge clk);
        init_req = 1'b0;
        count_init(50, na, nb, nc, nr);
        zero_models();
        n_cmp++;
        if (na < 513 || na > 515 || nb < 513 || nb > 515) begin
            n_bad++;
            $display("FAIL drain_init_len: got a=%0d b=%0d, want 513..515", na, nb);
        end
        n_cmp++;
        if (nr != 0) begin
            n_bad++;
            $display("FAIL busy_ready: got %0d ready cycles, want 0", nr);
        end
        drain_rsp("init_req_rsp");
        issue(1'b0, 10'h005, 32'h0, 32'h0);
        issue(1'b0, 10'h200, 32'h0, 32'h0);
        drain_rsp("after_init");
    endtask

    task automatic test_reset_mid_init();
        int na, nb, nc, nr;
        issue(1'b1, 10'h005, 32'hCAFEF00D, 32'hFFFFFFFF);
        issue(1'b0, 10'h005, 32'h0, 32'h0);
        drain_rsp("pre_reset");
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        repeat (100) @(negedge clk);
        #2;
        nreset = 1'b0;
        #1;
        n_cmp++;
        if (ia.req_ready !== 1'b0 || busy_a !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_rst_state: got ready=%b busy=%b, want 0/1", ia.req_ready, busy_a);
        end
        n_cmp++;
        if (ib.rsp_dout !== 32'h0 || ib.rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_rst_out_b: got %h/%b, want 0/0", ib.rsp_dout, ib.rsp_valid);
        end
        @(negedge clk);
        nreset = 1'b1;
        count_init(-1, na, nb, nc, nr);
        zero_models();
        n_cmp++;
        if (na != 512 || nb != 512 || nc != 64) begin
            n_bad++;
            $display("FAIL reinit_len: got a=%0d b=%0d c=%0d, want 512/512/64", na, nb, nc);
        end
        issue(1'b0, 10'h005, 32'h0, 32'h0);
        issue_c(1'b0, 5'h1F, 12'h0, 12'h0);
        drain_rsp("after_reinit");
    endtask

    initial begin
        nreset     = 1'b0;
        init_req   = 1'b0;
        init_req_c = 1'b0;
        vss        = 1'b0;
        vdd        = 1'b1;
        ctrl       = '0;
        test       = '0;
        s_valid    = 1'b0;
        s_we       = 1'b0;
        s_addr     = '0;
        s_din      = '0;
        s_mask     = '0;
        c_valid    = 1'b0;
        c_we       = 1'b0;
        c_addr     = '0;
        c_din      = '0;
        c_mask     = '0;
        zero_models();
        @(negedge clk);
        test_reset();
        test_write_read();
        test_back_to_back();
        test_dw12();
        test_init_req();
        test_reset_mid_init();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
